// File: rtl/tdm_pkg.sv
// Shared constants and the channel-select encoding for the 4:1 TDM mux.
// CH0..CH3 map directly onto the downstream demux select lines {s1,s0}.
package tdm_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [SEL_W-1:0] {
    CH0 = 2'b00,
    CH1 = 2'b01,
    CH2 = 2'b10,
    CH3 = 2'b11
  } ch_sel_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: scans ptr, ptr+1, ptr+2, ptr+3 (mod 4)
// and grants the first requesting channel when enabled.
module rr_arbiter4
  import tdm_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              any
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      // 2-bit add wraps naturally, giving the modulo-4 rotation.
      idx = ptr + SEL_W'(i);
      if (en && !any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/tdm_mux4.sv
// Four-channel round-robin TDM multiplexer: interleaves four valid/ready sources
// onto one registered stream tagged with the demux channel select.
module tdm_mux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*8-1:0]     grant_cnt
);

  logic              load;
  logic              any;
  logic [SEL_W-1:0]  gnt_idx;
  logic [NUM_CH-1:0] gnt;
  ch_sel_t           ptr;
  logic [WIDTH-1:0]  words [NUM_CH];
  logic [7:0]        cnt   [NUM_CH];

  // Output register is empty or drains this cycle; nothing is accepted during reset.
  assign load = !out_valid || out_ready;

  rr_arbiter4 u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .en      (load && rst_n),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign in_ready = gnt;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      words[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      grant_cnt[i*8 +: 8] = cnt[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= CH0;
      ptr       <= CH0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
      end
    end else if (load) begin
      if (any) begin
        out_valid     <= 1'b1;
        out_data      <= words[gnt_idx];
        out_sel       <= gnt_idx;
        ptr           <= ch_sel_t'(gnt_idx + 2'd1);
        cnt[gnt_idx]  <= cnt[gnt_idx] + 8'd1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tdm_mux4.sv
// Bench for tdm_mux4: directed scenarios plus randomized sources, all checked
// cycle by cycle against a behavioural model of the round-robin TDM link.
module tb_tdm_mux4;

  localparam int WIDTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] grant_cnt;

  always #5 clk = ~clk;

  tdm_mux4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant_cnt (grant_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_valid, m_data, m_sel, m_ptr;
  int m_cnt [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_grant(input logic [3:0] vld, input logic ordy);
    int ch;
    if (m_valid != 0 && !ordy) return -1;
    for (int k = 0; k < 4; k++) begin
      ch = (m_ptr + k) % 4;
      if (vld[ch]) return ch;
    end
    return -1;
  endfunction

  function automatic logic [31:0] model_cnt_packed();
    return 32'(m_cnt[0] + 256 * m_cnt[1] + 65536 * m_cnt[2] + 16777216 * m_cnt[3]);
  endfunction

  function automatic void model_reset();
    m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endfunction

  // One clock cycle: drive inputs, check everything at the falling edge, advance model.
  task automatic step(input logic [3:0] vld, input logic [31:0] data, input logic ordy, output int g);
    in_valid  = vld;
    in_data   = data;
    out_ready = ordy;
    @(negedge clk);
    g = model_grant(vld, ordy);
    check("in_ready",  32'(in_ready),  (g >= 0) ? (32'd1 << g) : 32'd0);
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data",  32'(out_data),  32'(m_data));
    check("out_sel",   32'(out_sel),   32'(m_sel));
    check("grant_cnt", grant_cnt,      model_cnt_packed());
    if (m_valid == 0 || ordy) begin
      if (g >= 0) begin
        m_valid  = 1;
        m_data   = int'((data >> (8 * g)) & 32'hFF);
        m_sel    = g;
        m_ptr    = (g + 1) % 4;
        m_cnt[g] = (m_cnt[g] + 1) % 256;
      end else begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted away from the clock edge, random inputs applied.
  task automatic do_reset();
    #2;
    rst_n     = 1'b0;
    in_valid  = 4'($urandom);
    in_data   = $urandom;
    out_ready = 1'($urandom);
    #1;
    model_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sel",   32'(out_sel),   32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_grant_cnt", grant_cnt,      32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_valid", 32'(out_valid), 32'd0);
    in_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] FULL_DATA = 32'hD3C2B1A0;

  initial begin
    int         g;
    bit   [3:0] src_v;
    logic [7:0] src_d [4];
    logic [7:0] exp_d [5];
    int         exp_s [5];

    exp_d[0] = 8'hA0; exp_d[1] = 8'hB1; exp_d[2] = 8'hC2; exp_d[3] = 8'hD3; exp_d[4] = 8'hA0;
    exp_s[0] = 0; exp_s[1] = 1; exp_s[2] = 2; exp_s[3] = 3; exp_s[4] = 0;

    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    do_reset();

    // Full load, no bubbles
    for (int i = 0; i < 5; i++) begin
      step(4'hF, FULL_DATA, 1'b1, g);
      check("full_sel",   32'(out_sel),   32'(exp_s[i]));
      check("full_data",  32'(out_data),  32'(exp_d[i]));
      check("full_valid", 32'(out_valid), 32'd1);
    end

    // Backpressure: channels 1 and 3 valid
    do_reset();
    step(4'b1010, 32'h44332211, 1'b1, g);
    check("bp_first_sel", 32'(out_sel), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(4'b1010, 32'h44332211, 1'b0, g);
      check("bp_hold_sel",  32'(out_sel),  32'd1);
      check("bp_hold_data", 32'(out_data), 32'h22);
    end
    step(4'b1010, 32'h44332211, 1'b1, g);
    check("bp_release_sel",  32'(out_sel),  32'd3);
    check("bp_release_data", 32'(out_data), 32'h44);

    // Sparse: one word on channel 2
    do_reset();
    step(4'b0100, 32'h005A0000, 1'b1, g);
    check("sparse_sel",  32'(out_sel),  32'd2);
    check("sparse_data", 32'(out_data), 32'h5A);
    step(4'b0000, 32'h0, 1'b1, g);
    check("sparse_drop", 32'(out_valid), 32'd0);
    check("sparse_hold", 32'(out_data),  32'h5A);
    step(4'b1111, FULL_DATA, 1'b1, g);
    check("sparse_ptr3", 32'(out_sel), 32'd3);

    // Counter wrap on channel 0 with channel 1 already counted once
    do_reset();
    step(4'b0010, FULL_DATA, 1'b1, g);
    for (int i = 0; i < 256; i++) begin
      step(4'b0001, 32'($urandom), 1'b1, g);
      if (i == 254) check("cnt0_255", grant_cnt, 32'h0000_01FF);
    end
    check("cnt0_wrap", grant_cnt, 32'h0000_0100);

    // Reset mid-stream while channel 2 word is held
    do_reset();
    step(4'hF, FULL_DATA, 1'b1, g);
    step(4'hF, FULL_DATA, 1'b1, g);
    step(4'hF, FULL_DATA, 1'b1, g);
    step(4'hF, FULL_DATA, 1'b0, g);
    check("mid_pre_sel",   32'(out_sel),   32'd2);
    check("mid_pre_valid", 32'(out_valid), 32'd1);
    do_reset();
    step(4'hF, FULL_DATA, 1'b1, g);
    check("mid_restart_sel",  32'(out_sel),  32'd0);
    check("mid_restart_data", 32'(out_data), 32'hA0);

    // Randomized sources honouring the hold-until-ready handshake
    do_reset();
    src_v = '0;
    for (int i = 0; i < 4; i++) src_d[i] = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (!src_v[ch] && $urandom_range(0, 1) == 1) begin
          src_v[ch] = 1'b1;
          src_d[ch] = 8'($urandom);
        end
      end
      step(src_v, {src_d[3], src_d[2], src_d[1], src_d[0]},
           1'($urandom_range(0, 3) != 0), g);
      if (g >= 0) src_v[g] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
